rvga_lsu: RTL

- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU effective address, computed with address-calculation mode, together with store data and the memory funct3.
- Runs one valid/ready transaction on the data-memory port, then aligns or extends load data.
- Holds the result for writeback until it is consumed; one transaction is outstanding at a time.

---
 rtl/rvga_types_pkg.sv | 29 ++
 rtl/rvga_lsu_align.sv | 86 ++++++++
 rtl/rvga_lsu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rvga_types_pkg.sv
// rvga_types: shared RV32 type definitions for the execute/memory slice.
// Provides the word and funct3 types, the LSU state and fault encodings,
// and the memory-width funct3 constants used by the load/store unit.
package rvga_types;

    typedef logic [31:0] rvga_word;
    typedef logic [2:0]  rvga_funct3;

    typedef enum logic [1:0] {
        e_lsu_idle = 2'd0,
        e_lsu_req  = 2'd1,
        e_lsu_resp = 2'd2,
        e_lsu_done = 2'd3
    } rvga_lsu_state_e;

    typedef enum logic [1:0] {
        e_lsu_fault_none       = 2'd0,
        e_lsu_fault_misaligned = 2'd1,
        e_lsu_fault_illegal    = 2'd2,
        e_lsu_fault_timeout    = 2'd3
    } rvga_lsu_fault_e;

    localparam rvga_funct3 e_rvga_memop_b  = 3'b000;
    localparam rvga_funct3 e_rvga_memop_h  = 3'b001;
    localparam rvga_funct3 e_rvga_memop_w  = 3'b010;
    localparam rvga_funct3 e_rvga_memop_bu = 3'b100;
    localparam rvga_funct3 e_rvga_memop_hu = 3'b101;

endpackage

// File: rtl/rvga_lsu_align.sv
// rvga_lsu_align: combinational byte-lane logic for the LSU.
// Ports:
//   store_i      1 = store, 0 = load
//   funct3_i     memory width/sign
//   addr_lo_i    address bits [1:0]
//   data_i       store data (rs2)
//   rdata_i      raw load word from memory
//   wdata_o      replicated store data
//   wmask_o      byte enables
//   ldata_o      extracted and extended load data
//   misaligned_o access not naturally aligned for its width
//   illegal_o    funct3 not a valid load/store encoding
module rvga_lsu_align
    import rvga_types::*;
(
    input  logic       store_i,
    input  rvga_funct3 funct3_i,
    input  logic [1:0] addr_lo_i,
    input  rvga_word   data_i,
    input  rvga_word   rdata_i,
    output rvga_word   wdata_o,
    output logic [3:0] wmask_o,
    output rvga_word   ldata_o,
    output logic       misaligned_o,
    output logic       illegal_o
);

    function automatic rvga_word sext8(input logic [7:0] b);
        logic signed [7:0] s;
        s = signed'(b);
        return 32'(s);
    endfunction

    function automatic rvga_word sext16(input logic [15:0] h);
        logic signed [15:0] s;
        s = signed'(h);
        return 32'(s);
    endfunction

    rvga_word lane;

    // Shift the addressed byte down to lane 0 before extension.
    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        wdata_o = data_i;
        wmask_o = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {4{data_i[7:0]}};
                wmask_o = 4'b0001 << addr_lo_i;
            end
            2'b01: begin
                wdata_o = {2{data_i[15:0]}};
                wmask_o = 4'b0011 << addr_lo_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        ldata_o = rdata_i;
        case (funct3_i)
            e_rvga_memop_b:  ldata_o = sext8(lane[7:0]);
            e_rvga_memop_h:  ldata_o = sext16(lane[15:0]);
            e_rvga_memop_bu: ldata_o = {24'd0, lane[7:0]};
            e_rvga_memop_hu: ldata_o = {16'd0, lane[15:0]};
            default:         ldata_o = rdata_i;
        endcase
    end

    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b0;
        endcase
    end

    // Stores only have B/H/W; loads additionally have BU/HU.
    assign illegal_o = store_i ? (funct3_i > e_rvga_memop_w)
                               : ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                                  (funct3_i == 3'b111));

endmodule

// File: rtl/rvga_lsu.sv
// rvga_lsu: load/store unit after the execute-stage ALU.
// Accepts one operation at a time, runs a valid/ready request on the data
// memory port, waits for the response (with timeout), then holds the
// extended result until writeback consumes it.
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   v_i/ready_o               operation handshake from execute
//   store_i, funct3_i, addr_i, data_i, rd_i   operation fields
//   mem_v_o/mem_ready_i       memory request handshake
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o  request fields
//   mem_resp_v_i, mem_rdata_i memory response
//   v_o/yumi_i                result handshake to writeback
//   rd_o, data_o, fault_o     result fields
module rvga_lsu
    import rvga_types::*;
#(
    parameter int addr_width_p = 32,
    parameter int max_wait_p   = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic                    store_i,
    input  rvga_funct3              funct3_i,
    input  rvga_word                addr_i,
    input  rvga_word                data_i,
    input  logic [4:0]              rd_i,
    output logic                    mem_v_o,
    input  logic                    mem_ready_i,
    output logic                    mem_we_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output rvga_word                mem_wdata_o,
    output logic [3:0]              mem_wmask_o,
    input  logic                    mem_resp_v_i,
    input  rvga_word                mem_rdata_i,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [4:0]              rd_o,
    output rvga_word                data_o,
    output rvga_lsu_fault_e         fault_o
);

    localparam int cnt_w_lp = $clog2(max_wait_p + 1);
    localparam logic [cnt_w_lp-1:0] wait_last_lp = cnt_w_lp'(max_wait_p - 1);

    rvga_lsu_state_e           state_q, state_n;
    logic                      store_q;
    rvga_funct3                funct3_q;
    logic [addr_width_p-1:0]   addr_q;
    rvga_word                  data_q;
    logic [4:0]                rd_q;
    rvga_word                  result_q;
    rvga_lsu_fault_e           fault_q;
    logic [cnt_w_lp-1:0]       wait_q;

    logic       idle;
    logic       al_store;
    rvga_funct3 al_funct3;
    logic [1:0] al_addr_lo;
    rvga_word   al_data;
    rvga_word   ldata;
    logic       misaligned, illegal;

    // While idle the checks must see the incoming operation; afterwards the
    // aligner works on the latched copy so request fields stay stable.
    assign idle       = (state_q == e_lsu_idle);
    assign al_store   = idle ? store_i       : store_q;
    assign al_funct3  = idle ? funct3_i      : funct3_q;
    assign al_addr_lo = idle ? addr_i[1:0]   : addr_q[1:0];
    assign al_data    = idle ? data_i        : data_q;

    rvga_lsu_align u_align (
        .store_i      (al_store),
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .data_i       (al_data),
        .rdata_i      (mem_rdata_i),
        .wdata_o      (mem_wdata_o),
        .wmask_o      (mem_wmask_o),
        .ldata_o      (ldata),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    assign mem_we_o   = store_q;
    assign mem_addr_o = {addr_q[addr_width_p-1:2], 2'b00};
    assign rd_o       = rd_q;
    assign data_o     = result_q;
    assign fault_o    = fault_q;

    always_comb begin
        state_n = state_q;
        ready_o = 1'b0;
        mem_v_o = 1'b0;
        v_o     = 1'b0;
        case (state_q)
            e_lsu_idle: begin
                ready_o = 1'b1;
                if (v_i) state_n = (illegal || misaligned) ? e_lsu_done : e_lsu_req;
            end
            e_lsu_req: begin
                mem_v_o = 1'b1;
                if (mem_ready_i) state_n = e_lsu_resp;
            end
            e_lsu_resp: begin
                if (mem_resp_v_i || (wait_q == wait_last_lp)) state_n = e_lsu_done;
            end
            e_lsu_done: begin
                v_o = 1'b1;
                if (yumi_i) state_n = e_lsu_idle;
            end
            default: state_n = e_lsu_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_lsu_idle;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= '0;
            result_q <= '0;
            fault_q  <= e_lsu_fault_none;
            wait_q   <= '0;
        end else begin
            state_q <= state_n;
            case (state_q)
                // Accept: latch operation, resolve illegal/misaligned up front.
                e_lsu_idle: begin
                    if (v_i) begin
                        store_q  <= store_i;
                        funct3_q <= funct3_i;
                        addr_q   <= addr_i[addr_width_p-1:0];
                        data_q   <= data_i;
                        result_q <= '0;
                        if (illegal) begin
                            fault_q <= e_lsu_fault_illegal;
                            rd_q    <= '0;
                        end else if (misaligned) begin
                            fault_q <= e_lsu_fault_misaligned;
                            rd_q    <= '0;
                        end else begin
                            fault_q <= e_lsu_fault_none;
                            rd_q    <= rd_i;
                        end
                    end
                end
                // Request: fields held from the latched op until handshake.
                e_lsu_req: begin
                    if (mem_ready_i) wait_q <= '0;
                end
                // Response: a response in the final wait cycle beats the timeout.
                e_lsu_resp: begin
                    if (mem_resp_v_i) begin
                        result_q <= store_q ? '0 : ldata;
                        if (store_q) rd_q <= '0;
                    end else begin
                        wait_q <= wait_q + cnt_w_lp'(1);
                        if (wait_q == wait_last_lp) begin
                            fault_q  <= e_lsu_fault_timeout;
                            rd_q     <= '0;
                            result_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
